// File: rtl/approx_mon_pkg.sv
// Shared types and helpers for the approximate-arithmetic error monitors.
package approx_mon_pkg;

  localparam int ERR_W = 10;
  localparam int ABS_W = 9;
  localparam int SQ_W  = 18;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DRAIN  = 2'd1,
    REPORT = 2'd2
  } mon_state_e;

  function automatic logic signed [ERR_W-1:0] sext8(input logic [7:0] x);
    return {{(ERR_W-8){x[7]}}, x};
  endfunction

  function automatic logic signed [ERR_W-1:0] sext9(input logic [8:0] x);
    return {{(ERR_W-9){x[8]}}, x};
  endfunction

endpackage

// File: rtl/approx_err_calc.sv
// Combinational error arithmetic: exact sum, signed error, magnitude and square.
module approx_err_calc
  import approx_mon_pkg::*;
(
  input  logic [7:0]       i_a,
  input  logic [7:0]       i_b,
  input  logic [8:0]       i_o,
  input  logic [ABS_W-1:0] i_sq_abs,
  output logic [ABS_W-1:0] o_abs,
  output logic [SQ_W-1:0]  o_sq
);

  logic signed [ERR_W-1:0] w_exact;
  logic signed [ERR_W-1:0] w_err;

  assign w_exact = sext8(i_a) + sext8(i_b);
  assign w_err   = sext9(i_o) - w_exact;

  // Negative errors never go below -510, so the magnitude fits in the low 9 bits.
  assign o_abs = w_err[ERR_W-1] ? (~w_err[ABS_W-1:0] + 9'd1) : w_err[ABS_W-1:0];

  assign o_sq = {{(SQ_W-ABS_W){1'b0}}, i_sq_abs} * {{(SQ_W-ABS_W){1'b0}}, i_sq_abs};

endmodule

// File: rtl/approx_add_err_monitor.sv
// Windowed error statistics (MAE/MSE/WCE/EP sums) for an 8-bit approximate adder.
module approx_add_err_monitor
  import approx_mon_pkg::*;
#(
  parameter int LOG2_WIN = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [7:0]                in_a,
  input  logic [7:0]                in_b,
  input  logic [8:0]                in_o,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [ABS_W+LOG2_WIN-1:0] res_sum_abs,
  output logic [SQ_W+LOG2_WIN-1:0]  res_sum_sq,
  output logic [ABS_W-1:0]          res_max_abs,
  output logic [LOG2_WIN:0]         res_err_cnt
);

  mon_state_e                r_state;
  logic [LOG2_WIN-1:0]       r_cnt;
  logic                      r_drain;
  logic                      r_in_ready;
  logic                      r_res_valid;
  logic                      r_vld_p1;
  logic [ABS_W-1:0]          r_abs_p1;
  logic [ABS_W+LOG2_WIN-1:0] r_sum_abs;
  logic [SQ_W+LOG2_WIN-1:0]  r_sum_sq;
  logic [ABS_W-1:0]          r_max_abs;
  logic [LOG2_WIN:0]         r_err_cnt;

  logic [ABS_W-1:0]          w_abs;
  logic [SQ_W-1:0]           w_sq;
  logic                      w_accept;
  logic                      w_final;
  logic                      w_ack;

  approx_err_calc u_calc (
    .i_a      (in_a),
    .i_b      (in_b),
    .i_o      (in_o),
    .i_sq_abs (r_abs_p1),
    .o_abs    (w_abs),
    .o_sq     (w_sq)
  );

  assign w_accept = in_valid && r_in_ready && (r_state == ACCUM);
  assign w_final  = w_accept && (r_cnt == {LOG2_WIN{1'b1}});
  assign w_ack    = r_res_valid && res_ready;

  // Control: window FSM, sample counter, stage-1 valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ACCUM;
      r_cnt       <= '0;
      r_drain     <= 1'b0;
      r_in_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_vld_p1    <= 1'b0;
    end else if (clear) begin
      r_state     <= ACCUM;
      r_cnt       <= '0;
      r_drain     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_res_valid <= 1'b0;
      r_vld_p1    <= 1'b0;
    end else begin
      r_vld_p1 <= w_accept;
      case (r_state)
        ACCUM: begin
          r_in_ready <= !w_final;
          if (w_accept) r_cnt <= r_cnt + LOG2_WIN'(1);
          if (w_final) begin
            r_state <= DRAIN;
            r_drain <= 1'b0;
          end
        end
        DRAIN: begin
          if (r_drain) begin
            r_state     <= REPORT;
            r_res_valid <= 1'b1;
          end else begin
            r_drain <= 1'b1;
          end
        end
        REPORT: begin
          if (res_ready) begin
            r_state     <= ACCUM;
            r_res_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  // Stage 1: register the error magnitude of the accepted sample
  always_ff @(posedge clk) begin
    if (w_accept) r_abs_p1 <= w_abs;
  end

  // Stage 2: window accumulators, which double as the registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_abs <= '0;
      r_sum_sq  <= '0;
      r_max_abs <= '0;
      r_err_cnt <= '0;
    end else if (clear || w_ack) begin
      r_sum_abs <= '0;
      r_sum_sq  <= '0;
      r_max_abs <= '0;
      r_err_cnt <= '0;
    end else if (r_vld_p1) begin
      r_sum_abs <= r_sum_abs + {{LOG2_WIN{1'b0}}, r_abs_p1};
      r_sum_sq  <= r_sum_sq + {{LOG2_WIN{1'b0}}, w_sq};
      if (r_abs_p1 >= r_max_abs) r_max_abs <= r_abs_p1;
      if (r_abs_p1 != '0) r_err_cnt <= r_err_cnt + (LOG2_WIN+1)'(1);
    end
  end

  assign in_ready    = r_in_ready;
  assign res_valid   = r_res_valid;
  assign res_sum_abs = r_sum_abs;
  assign res_sum_sq  = r_sum_sq;
  assign res_max_abs = r_max_abs;
  assign res_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_approx_add_err_monitor.sv
// Randomised self-checking bench for approx_add_err_monitor with a 4-sample window.
module tb_approx_add_err_monitor;

  localparam int L = 2;
  localparam int WIN = 1 << L;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_a = '0;
  logic [7:0]    in_b = '0;
  logic [8:0]    in_o = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [8+L:0]  res_sum_abs;
  logic [17+L:0] res_sum_sq;
  logic [8:0]    res_max_abs;
  logic [L:0]    res_err_cnt;

  int n_vec = 0;
  int n_fail = 0;
  int m_abs, m_sq, m_max, m_cnt;

  always #5 clk = ~clk;

  approx_add_err_monitor #(.LOG2_WIN(L)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_o(in_o),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum_abs(res_sum_abs), .res_sum_sq(res_sum_sq),
    .res_max_abs(res_max_abs), .res_err_cnt(res_err_cnt)
  );

  // Reference model: error statistics straight from integer arithmetic.
  task automatic model_reset();
    m_abs = 0; m_sq = 0; m_max = 0; m_cnt = 0;
  endtask

  task automatic model_add(input logic [7:0] a, input logic [7:0] b, input logic [8:0] o);
    int ia, ib, io, e;
    ia = int'($signed(a)); ib = int'($signed(b)); io = int'($signed(o));
    e = io - (ia + ib);
    if (e < 0) e = -e;
    m_abs += e;
    m_sq += e * e;
    if (e > m_max) m_max = e;
    if (e != 0) m_cnt++;
  endtask

  task automatic gen(output logic [7:0] a, output logic [7:0] b, output logic [8:0] o);
    int s, d;
    a = 8'($urandom);
    b = 8'($urandom);
    s = int'($signed(a)) + int'($signed(b));
    d = int'($urandom_range(0, 6)) - 3;
    case ($urandom_range(0, 2))
      0:       o = 9'(s);
      1:       o = 9'($urandom);
      default: o = 9'(s + d);
    endcase
  endtask

  // Present one sample and hold it until the DUT takes it (bounded).
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [8:0] o);
    int t;
    logic rdy;
    t = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_o = o;
    do begin
      rdy = in_ready;
      @(posedge clk); #1;
      t++;
    end while (!rdy && t < 50);
    if (!rdy) begin
      n_vec++; n_fail++;
      $display("FAIL send_timeout in_ready stayed %0b, required 1", in_ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_rand_window(input bit modelled);
    logic [7:0] a, b;
    logic [8:0] o;
    for (int i = 0; i < WIN; i++) begin
      gen(a, b, o);
      if (modelled) model_add(a, b, o);
      send(a, b, o);
    end
  endtask

  task automatic wait_res(input string tag);
    int t;
    t = 0;
    while (!res_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!res_valid) begin
      n_vec++; n_fail++;
      $display("FAIL %s res_valid_timeout got 0 required 1", tag);
    end
  endtask

  task automatic ack();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %0b required 0", in_ready); end
    n_vec++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid got %0b required 0", res_valid); end
    n_vec++;
    if ({res_sum_abs, res_sum_sq, res_max_abs, res_err_cnt} !== '0) begin
      n_fail++;
      $display("FAIL rst_stats got %0d/%0d/%0d/%0d required 0/0/0/0", res_sum_abs, res_sum_sq, res_max_abs, res_err_cnt);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_in_ready got %0b required 1", in_ready); end
  endtask

  task automatic test_basic();
    send(8'd3, 8'd5, 9'd8);
    send(8'd3, 8'd5, 9'd9);
    send(8'h80, 8'h80, 9'h0FF);
    send(8'd0, 8'd0, 9'h1F0);
    n_vec++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_lat0 res_valid got %0b required 0", res_valid); end
    @(posedge clk); #1;
    n_vec++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_lat1 res_valid got %0b required 0", res_valid); end
    @(posedge clk); #1;
    n_vec++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL basic_lat2 res_valid got %0b required 1", res_valid); end
    n_vec++; if (res_sum_abs !== 528) begin n_fail++; $display("FAIL basic_sum_abs got %0d required 528", res_sum_abs); end
    n_vec++; if (res_sum_sq !== 261378) begin n_fail++; $display("FAIL basic_sum_sq got %0d required 261378", res_sum_sq); end
    n_vec++; if (res_max_abs !== 511) begin n_fail++; $display("FAIL basic_max got %0d required 511", res_max_abs); end
    n_vec++; if (res_err_cnt !== 3) begin n_fail++; $display("FAIL basic_cnt got %0d required 3", res_err_cnt); end
    ack();
    n_vec++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_ack_valid got %0b required 0", res_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ack_in_ready got %0b required 1", in_ready); end
    n_vec++; if (res_sum_abs !== 0) begin n_fail++; $display("FAIL basic_ack_zero got %0d required 0", res_sum_abs); end
  endtask

  task automatic test_exact();
    logic [7:0] a, b;
    for (int i = 0; i < WIN; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      send(a, b, 9'(int'($signed(a)) + int'($signed(b))));
    end
    wait_res("exact");
    n_vec++;
    if ({res_sum_abs, res_sum_sq, res_max_abs, res_err_cnt} !== '0) begin
      n_fail++;
      $display("FAIL exact_stats got %0d/%0d/%0d/%0d required 0/0/0/0", res_sum_abs, res_sum_sq, res_max_abs, res_err_cnt);
    end
    ack();
  endtask

  task automatic test_hold();
    logic [7:0] a, b;
    logic [8:0] o;
    model_reset();
    send_rand_window(1'b1);
    wait_res("hold");
    for (int c = 0; c < 10; c++) begin
      gen(a, b, o);
      in_valid = 1'b1; in_a = a; in_b = b; in_o = o;
      @(posedge clk); #1;
      n_vec++;
      if (res_valid !== 1'b1 || in_ready !== 1'b0 || res_sum_abs !== m_abs || res_sum_sq !== m_sq ||
          res_max_abs !== m_max || res_err_cnt !== m_cnt) begin
        n_fail++;
        $display("FAIL hold_c%0d got v%0b r%0b %0d/%0d/%0d/%0d required v1 r0 %0d/%0d/%0d/%0d", c, res_valid, in_ready,
                 res_sum_abs, res_sum_sq, res_max_abs, res_err_cnt, m_abs, m_sq, m_max, m_cnt);
      end
    end
    in_valid = 1'b0;
    ack();
    model_reset();
    send_rand_window(1'b1);
    wait_res("hold2");
    n_vec++;
    if (res_sum_abs !== m_abs || res_sum_sq !== m_sq || res_max_abs !== m_max || res_err_cnt !== m_cnt) begin
      n_fail++;
      $display("FAIL hold_win2 got %0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d", res_sum_abs, res_sum_sq, res_max_abs,
               res_err_cnt, m_abs, m_sq, m_max, m_cnt);
    end
    ack();
  endtask

  task automatic test_clear();
    logic [7:0] a, b;
    model_reset();
    send(8'd10, 8'd10, 9'd100);
    send(8'd1, 8'd1, 9'd50);
    in_valid = 1'b1; in_a = 8'd0; in_b = 8'd0; in_o = 9'd200;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (res_sum_abs !== 0 || res_err_cnt !== 0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_mid got abs %0d cnt %0d rdy %0b required 0 0 1", res_sum_abs, res_err_cnt, in_ready);
    end
    send_rand_window(1'b1);
    wait_res("clear_win");
    n_vec++;
    if (res_sum_abs !== m_abs || res_sum_sq !== m_sq || res_max_abs !== m_max || res_err_cnt !== m_cnt) begin
      n_fail++;
      $display("FAIL clear_win got %0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d", res_sum_abs, res_sum_sq, res_max_abs,
               res_err_cnt, m_abs, m_sq, m_max, m_cnt);
    end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    n_vec++;
    if (res_valid !== 1'b0 || res_sum_sq !== 0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_report got v%0b sq %0d rdy %0b required v0 0 1", res_valid, res_sum_sq, in_ready);
    end
    model_reset();
    for (int i = 0; i < WIN; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      model_add(a, b, 9'd7);
      send(a, b, 9'd7);
    end
    wait_res("clear_after");
    n_vec++;
    if (res_sum_abs !== m_abs || res_err_cnt !== m_cnt) begin
      n_fail++;
      $display("FAIL clear_after got %0d/%0d required %0d/%0d", res_sum_abs, res_err_cnt, m_abs, m_cnt);
    end
    ack();
  endtask

  task automatic test_rst_drain();
    int seen;
    model_reset();
    send(8'd20, 8'd20, 9'd0);
    send(8'd20, 8'd20, 9'd0);
    send(8'd20, 8'd20, 9'd0);
    send(8'd20, 8'd20, 9'd0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (res_valid !== 1'b0 || in_ready !== 1'b0 || res_sum_abs !== 0 || res_sum_sq !== 0 || res_err_cnt !== 0) begin
      n_fail++;
      $display("FAIL rst_drain got v%0b r%0b abs %0d sq %0d cnt %0d required all 0", res_valid, in_ready,
               res_sum_abs, res_sum_sq, res_err_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (res_valid === 1'b1) seen++;
    end
    n_vec++; if (seen != 0) begin n_fail++; $display("FAIL rst_no_report got %0d valid cycles required 0", seen); end
    send_rand_window(1'b1);
    wait_res("rst_resume");
    n_vec++;
    if (res_sum_abs !== m_abs || res_sum_sq !== m_sq || res_max_abs !== m_max || res_err_cnt !== m_cnt) begin
      n_fail++;
      $display("FAIL rst_resume got %0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d", res_sum_abs, res_sum_sq, res_max_abs,
               res_err_cnt, m_abs, m_sq, m_max, m_cnt);
    end
    ack();
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    logic [8:0] o;
    for (int w = 0; w < 1000; w++) begin
      model_reset();
      for (int i = 0; i < WIN; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
        gen(a, b, o);
        model_add(a, b, o);
        send(a, b, o);
      end
      wait_res("b2b");
      n_vec++;
      if (res_sum_abs !== m_abs || res_sum_sq !== m_sq || res_max_abs !== m_max || res_err_cnt !== m_cnt) begin
        n_fail++;
        $display("FAIL b2b_w%0d got %0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d", w, res_sum_abs, res_sum_sq,
                 res_max_abs, res_err_cnt, m_abs, m_sq, m_max, m_cnt);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
      ack();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_exact();
    test_hold();
    test_clear();
    test_rst_drain();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/approx_add_err_monitor.md
Name: approx_add_err_monitor

Overview:
- Downstream observer stage for an 8-bit signed approximate adder under test (9-bit output).
- Takes the adder's operands and its approximate sum as a streaming sample, computes the exact sum, and derives the signed and absolute error.
- Accumulates window statistics: sum of absolute error (for MAE), sum of squared error (for MSE), worst-case error (WCE) and error-occurrence count (for EP).
- Reports the statistics once per window of 2^LOG2_WIN samples over a valid/ready handshake, for on-chip characterisation of approximate adders in the CNN datapath.

Parameters:
- LOG2_WIN, 8, log2 of the number of samples per reporting window (1..16).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort: discards the window and restarts accumulation.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample accepted when in_valid && in_ready.
- in_a  in  8  operand A, two's complement.
- in_b  in  8  operand B, two's complement.
- in_o  in  9  approximate sum from the adder under test, two's complement.
- res_valid  out  1  window statistics valid.
- res_ready  in  1  consumer accepts the statistics.
- res_sum_abs  out  9+LOG2_WIN  sum of |err| over the window.
- res_sum_sq  out  18+LOG2_WIN  sum of err^2 over the window.
- res_max_abs  out  9  maximum |err| in the window.
- res_err_cnt  out  LOG2_WIN+1  number of samples with err != 0.

Behaviour:
- Arithmetic:
  - exact = sext10(in_a) + sext10(in_b), range -256..254.
  - err = sext10(in_o) - exact, range -510..511, 10-bit signed.
  - abs_err is 9-bit unsigned, max 511.
  - sq = abs_err*abs_err is 18-bit, max 261121.
  - No accumulator can overflow at full window; widths are exact, with no saturation.
- Pipeline:
  - S1 registers abs_err plus a valid bit on accept.
  - S2 updates the accumulators from the S1 registers (sq is computed from registered abs_err).
- State machine ACCUM, DRAIN, REPORT. Reset state is ACCUM.
  - ACCUM: in_ready=1. A sample counter (LOG2_WIN bits) increments per accept. The accept that wraps the counter to 0 (the 2^LOG2_WIN-th sample) moves the FSM to DRAIN.
  - DRAIN: in_ready=0. Lasts 2 cycles until S1/S2 are empty, then REPORT. res_valid rises exactly 2 cycles after the final sample's accept edge.
  - REPORT: in_ready=0, res_valid=1, outputs held stable.
  - res_valid && res_ready: accumulators, max and count are zeroed; the FSM returns to ACCUM on the same edge; in_ready=1 on the next cycle.
- Outputs are registered. On reset all res_* = 0, res_valid=0, in_ready=0 during reset, counters zeroed, pipeline valid bits cleared.
- clear (any state) has priority over every other event on that edge:
  - Zeroes the accumulators, the sample counter and the pipeline valid bits.
  - FSM goes to ACCUM and res_valid drops.
  - A sample presented in the clear cycle is dropped and not counted.
- Reset asserted mid-window discards all partial results; there is no partial report.
- in_valid while in_ready=0 is ignored. The upstream source must hold the sample.
- res_max_abs is updated with >= compare. Its value is 0 if all samples are exact.

Decomposition:
- Shared package approx_mon_pkg holds:
  - fsm state enum (ACCUM, DRAIN, REPORT);
  - width constants ERR_W=10, ABS_W=9, SQ_W=18;
  - function sext helpers.
- One sub-module, approx_err_calc: combinational exact sum, signed error, abs and square. It is reused by the later multiplier monitor.

Test Plan:
- LOG2_WIN=2, samples (3,5,O=8),(3,5,O=9),(-128,-128,O=0x0FF),(0,0,O=0x1F0) -> err 0,1,511,-16; res_sum_abs=528, res_sum_sq=261378, res_max_abs=511, res_err_cnt=3; res_valid 2 cycles after 4th accept.
- All 2^LOG2_WIN samples exact (O=A+B) -> all res_* = 0, res_valid=1.
- res_ready held low 10 cycles in REPORT -> outputs stable, in_ready=0, in_valid ignored. Then pulse res_ready -> next window starts from zero; 2nd window results are independent.
- clear asserted after 2 of 4 samples, plus clear while res_valid=1 -> counters reset, res_valid drops next edge; a following full window reports only post-clear samples.
- rst_n asserted low asynchronously mid-DRAIN -> outputs 0 immediately, no report emitted; operation resumes in ACCUM after release.
- Back-to-back in_valid every cycle with random bubbles, compared against a reference model over 1000 windows -> exact match of all four statistics.
